alu_op_sequencer: RTL and testbench

Command-driven controller that owns the accumulator and sequences the shared 8-bit combinational Alu. It accepts one command at a time over a valid/ready handshake and either loads the accumulator directly or iterates one ALU operation N+1 times. Each iteration writes result_ac back into AC. It sits between the instruction/decode logic and the Alu instance, and drives the Alu's AC, BusOut and ALU_OP inputs.

---
 rtl/alu_op_sequencer.sv | 104 ++++++++++
 tb/tb_alu_op_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - accumulator owner and repeat-count sequencer for the shared combinational Alu
module alu_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   input  logic [CNT_W-1:0] cmd_repeat,
   input  logic             halt,
   output logic [WIDTH-1:0] AC,
   output logic [WIDTH-1:0] BusOut,
   output logic [2:0]       ALU_OP,
   input  logic [WIDTH-1:0] result_ac,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter_left
);

   localparam logic [2:0] OP_IDLE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] ac_nxt;
   logic [WIDTH-1:0] bus_nxt;
   logic [2:0]       op_nxt;
   logic [CNT_W-1:0] iter_nxt;
   logic             accept;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state == ST_EXEC) || (state == ST_DONE);
   assign done      = (state == ST_DONE);
   // halt deliberately does not gate acceptance; it only freezes EXEC
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_nxt = state;
      ac_nxt    = AC;
      bus_nxt   = BusOut;
      op_nxt    = ALU_OP;
      iter_nxt  = iter_left;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_load) begin
                  ac_nxt    = cmd_operand;
                  state_nxt = ST_DONE;
               end else begin
                  bus_nxt   = cmd_operand;
                  op_nxt    = cmd_op;
                  iter_nxt  = cmd_repeat;
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            if (!halt) begin
               ac_nxt = result_ac;
               if (iter_left == '0) begin
                  // drop to the idle opcode as DONE is entered
                  op_nxt    = OP_IDLE;
                  state_nxt = ST_DONE;
               end else begin
                  iter_nxt = iter_left - CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            op_nxt    = OP_IDLE;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= ST_IDLE;
         AC        <= '0;
         BusOut    <= '0;
         ALU_OP    <= OP_IDLE;
         iter_left <= '0;
      end else begin
         state     <= state_nxt;
         AC        <= ac_nxt;
         BusOut    <= bus_nxt;
         ALU_OP    <= op_nxt;
         iter_left <= iter_nxt;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed-vector bench for alu_op_sequencer with a behavioural Alu stub
module tb_alu_op_sequencer;

   logic       Clk;
   logic       Rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_load;
   logic [2:0] cmd_op;
   logic [7:0] cmd_operand;
   logic [3:0] cmd_repeat;
   logic       halt;
   logic [7:0] AC;
   logic [7:0] BusOut;
   logic [2:0] ALU_OP;
   logic [7:0] result_ac;
   logic       busy;
   logic       done;
   logic [3:0] iter_left;

   int vectors = 0;
   int errors  = 0;

   alu_op_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand), .cmd_repeat(cmd_repeat),
      .halt(halt), .AC(AC), .BusOut(BusOut), .ALU_OP(ALU_OP),
      .result_ac(result_ac), .busy(busy), .done(done), .iter_left(iter_left)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always_comb begin
      case (ALU_OP)
         3'b001:  result_ac = AC + BusOut;
         3'b100:  result_ac = AC & BusOut;
         default: result_ac = AC;
      endcase
   end

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic issue(input logic ld, input logic [2:0] op, input logic [7:0] opnd, input logic [3:0] rep);
      cmd_valid   = 1'b1;
      cmd_load    = ld;
      cmd_op      = op;
      cmd_operand = opnd;
      cmd_repeat  = rep;
      tick();
      cmd_valid   = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      tick();
      tick();
      Rst = 1'b0;
      vectors++;
      if (AC !== 8'h00 || ALU_OP !== 3'b000 || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || iter_left !== 4'd0 || BusOut !== 8'h00) begin
         errors++;
         $display("FAIL reset: AC=%h ALU_OP=%b ready=%b done=%b busy=%b iter=%0d BusOut=%h, want 00 000 1 0 0 0 00",
                  AC, ALU_OP, cmd_ready, done, busy, iter_left, BusOut);
      end
   endtask

   task automatic test_load();
      issue(1'b1, 3'b111, 8'b00010101, 4'd9);
      vectors++;
      if (AC !== 8'h15 || done !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1 || ALU_OP !== 3'b000 || BusOut !== 8'h00) begin
         errors++;
         $display("FAIL load_accept: AC=%h done=%b ready=%b busy=%b op=%b bus=%h, want 15 1 0 1 000 00",
                  AC, done, cmd_ready, busy, ALU_OP, BusOut);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || AC !== 8'h15) begin
         errors++;
         $display("FAIL load_return: done=%b ready=%b busy=%b AC=%h, want 0 1 0 15", done, cmd_ready, busy, AC);
      end
   endtask

   task automatic test_single_op();
      issue(1'b0, 3'b001, 8'hAA, 4'd0);
      vectors++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0 || BusOut !== 8'hAA || ALU_OP !== 3'b001 || AC !== 8'h15 || done !== 1'b0) begin
         errors++;
         $display("FAIL add_accept: busy=%b ready=%b bus=%h op=%b AC=%h done=%b, want 1 0 aa 001 15 0",
                  busy, cmd_ready, BusOut, ALU_OP, AC, done);
      end
      tick();
      vectors++;
      if (AC !== 8'hBF || done !== 1'b1 || ALU_OP !== 3'b000) begin
         errors++;
         $display("FAIL add_result: AC=%h done=%b op=%b, want bf 1 000", AC, done, ALU_OP);
      end
      tick();
      issue(1'b0, 3'b100, 8'hAA, 4'd0);
      tick();
      vectors++;
      if (AC !== 8'hAA || done !== 1'b1) begin
         errors++;
         $display("FAIL and_result: AC=%h done=%b, want aa 1", AC, done);
      end
      tick();
   endtask

   task automatic test_repeat();
      logic [7:0] exp_ac;
      issue(1'b1, 3'b000, 8'h10, 4'd0);
      tick();
      issue(1'b0, 3'b001, 8'h30, 4'd5);
      vectors++;
      if (iter_left !== 4'd5 || AC !== 8'h10) begin
         errors++;
         $display("FAIL repeat_accept: iter=%0d AC=%h, want 5 10", iter_left, AC);
      end
      exp_ac = 8'h10;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_ac = exp_ac + 8'h30;
         vectors++;
         if (AC !== exp_ac || iter_left !== ((i < 6) ? 4'(5 - i) : 4'd0) || done !== (i == 6)) begin
            errors++;
            $display("FAIL repeat_step%0d: AC=%h iter=%0d done=%b, want %h %0d %0d",
                     i, AC, iter_left, done, exp_ac, (i < 6) ? (5 - i) : 0, (i == 6));
         end
      end
      vectors++;
      if (AC !== 8'h30) begin
         errors++;
         $display("FAIL repeat_wrap: AC=%h, want 30", AC);
      end
      tick();
   endtask

   task automatic test_halt();
      int cycles;
      issue(1'b1, 3'b000, 8'h10, 4'd0);
      tick();
      issue(1'b0, 3'b001, 8'h30, 4'd5);
      tick();
      tick();
      cycles = 2;
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         cycles++;
         vectors++;
         if (AC !== 8'h70 || iter_left !== 4'd3 || done !== 1'b0 || busy !== 1'b1 || ALU_OP !== 3'b001 || BusOut !== 8'h30) begin
            errors++;
            $display("FAIL halt_hold%0d: AC=%h iter=%0d done=%b busy=%b op=%b bus=%h, want 70 3 0 1 001 30",
                     i, AC, iter_left, done, busy, ALU_OP, BusOut);
         end
      end
      halt = 1'b0;
      while (done !== 1'b1 && cycles < 20) begin
         tick();
         cycles++;
      end
      vectors++;
      if (cycles !== 9 || AC !== 8'h30) begin
         errors++;
         $display("FAIL halt_latency: done after %0d cycles AC=%h, want 9 cycles AC=30", cycles, AC);
      end
      // halt is ignored in DONE
      halt = 1'b1;
      tick();
      vectors++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL halt_done_exit: ready=%b done=%b, want 1 0", cmd_ready, done);
      end
      halt = 1'b0;
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 3'b001, 8'h01, 4'd1);
      cmd_valid   = 1'b1;
      cmd_load    = 1'b1;
      cmd_operand = 8'hEE;
      tick();
      vectors++;
      if (AC !== 8'h31 || BusOut !== 8'h01 || iter_left !== 4'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_exec: AC=%h bus=%h iter=%0d done=%b, want 31 01 0 0", AC, BusOut, iter_left, done);
      end
      tick();
      vectors++;
      if (AC !== 8'h32 || done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_done: AC=%h done=%b, want 32 1", AC, done);
      end
      tick();
      vectors++;
      if (AC !== 8'h32 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL held_cmd_idle: AC=%h ready=%b done=%b, want 32 1 0", AC, cmd_ready, done);
      end
      tick();
      cmd_valid = 1'b0;
      vectors++;
      if (AC !== 8'hEE || done !== 1'b1) begin
         errors++;
         $display("FAIL held_cmd_accept: AC=%h done=%b, want ee 1", AC, done);
      end
      tick();
   endtask

   task automatic test_reset_mid_exec();
      issue(1'b0, 3'b001, 8'h01, 4'd5);
      tick();
      Rst = 1'b1;
      halt = 1'b1;
      tick();
      Rst = 1'b0;
      halt = 1'b0;
      vectors++;
      if (AC !== 8'h00 || ALU_OP !== 3'b000 || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || iter_left !== 4'd0 || BusOut !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_exec: AC=%h op=%b ready=%b done=%b busy=%b iter=%0d bus=%h, want 00 000 1 0 0 0 00",
                  AC, ALU_OP, cmd_ready, done, busy, iter_left, BusOut);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || AC !== 8'h00 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_done: done=%b AC=%h ready=%b, want 0 00 1", done, AC, cmd_ready);
      end
   endtask

   initial begin
      Rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_load    = 1'b0;
      cmd_op      = 3'b000;
      cmd_operand = 8'h00;
      cmd_repeat  = 4'd0;
      halt        = 1'b0;
      @(negedge Clk);
      test_reset();
      test_load();
      test_single_op();
      test_repeat();
      test_halt();
      test_back_to_back();
      test_reset_mid_exec();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
